memory_access_block: RTL and testbench

- MEM pipeline stage. It sits directly downstream of the execution stage and consumes that stage's EX/MEM register outputs.
- It performs Thumb load/store accesses to data memory over a req/ack handshake, including byte/halfword/word sizing, lane steering and sign extension.
- It stalls the pipeline while an access is outstanding.
- It drives MEM-stage forwarding data back to execute and registers results into the MEM/WB register.

---
 rtl/memory_access_block_pkg.sv | 53 +++++
 rtl/load_store_align.sv | 50 +++++
 rtl/memory_access_block.sv | 122 ++++++++++++
 tb/tb_memory_access_block.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_block_pkg.sv
// rtl/memory_access_block_pkg.sv - shared types, constants and access decode for the MEM stage
package memory_access_block_pkg;

    localparam int WORD       = 32;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic {MEM_WRITE_DIS = 1'b0, MEM_WRITE_EN = 1'b1} mem_write_signal;
    typedef enum logic {REG_WRITE_DIS = 1'b0, REG_WRITE_EN = 1'b1} reg_file_write_sig;
    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} reg_file_data_source;

    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD_ACC = 2'd2} mem_access_size;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_stage_state;

    localparam logic [3:0] OPA_LS_REG      = 4'b0101;
    localparam logic [3:0] OPA_LS_WORD_IMM = 4'b0110;
    localparam logic [3:0] OPA_LS_BYTE_IMM = 4'b0111;
    localparam logic [3:0] OPA_LS_HALF_IMM = 4'b1000;
    localparam logic [3:0] OPA_LS_SP       = 4'b1001;

    typedef struct packed {
        logic           is_signed;
        mem_access_size size;
    } access_decode_t;

    // Size/signedness from instruction[15:9]; non-memory opA falls back to a word view.
    function automatic access_decode_t decode_access(input logic [6:0] op);
        access_decode_t d;
        d.is_signed = 1'b0;
        d.size      = WORD_ACC;
        case (op[6:3])
            OPA_LS_REG: begin
                case (op[2:0])
                    3'b001, 3'b101: d.size = HALF;
                    3'b010, 3'b110: d.size = BYTE;
                    3'b011: begin
                        d.size      = BYTE;
                        d.is_signed = 1'b1;
                    end
                    3'b111: begin
                        d.size      = HALF;
                        d.is_signed = 1'b1;
                    end
                    default: d.size = WORD_ACC;
                endcase
            end
            OPA_LS_BYTE_IMM: d.size = BYTE;
            OPA_LS_HALF_IMM: d.size = HALF;
            default:         d.size = WORD_ACC;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering, store replication and load extension
module load_store_align
    import memory_access_block_pkg::*;
(
    input  mem_access_size   size,
    input  logic             is_signed,
    input  logic [1:0]       addr_lo,
    input  logic [WORD-1:0]  store_data,
    input  logic [WORD-1:0]  rdata,
    output logic [3:0]       be,
    output logic [WORD-1:0]  wdata,
    output logic [WORD-1:0]  load_data,
    output logic             misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[7:0];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            end
            HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                load_data  = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_block.sv
// rtl/memory_access_block.sv - MEM pipeline stage: data memory handshake, stall and MEM/WB register
module memory_access_block
    import memory_access_block_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    is_valid_i,
    input  mem_write_signal         mem_write_en_i,
    input  reg_file_write_sig       reg_file_write_en_i,
    input  reg_file_data_source     reg_file_data_source_i,
    input  logic [6:0]              opA_opB_i,
    input  logic [ADDR_WIDTH-1:0]   reg_dest_addr_i,
    input  logic [WORD-1:0]         alu_result_i,
    input  logic [WORD-1:0]         reg_2_data_i,
    input  logic [WORD-1:0]         dmem_rdata_i,
    input  logic                    dmem_ack_i,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [WORD-1:0]         dmem_addr_o,
    output logic [3:0]              dmem_be_o,
    output logic [WORD-1:0]         dmem_wdata_o,
    output logic                    stall_o,
    output logic                    misaligned_o,
    output reg_file_write_sig       reg_write_en_MEM_o,
    output logic [ADDR_WIDTH-1:0]   reg_dest_MEM_o,
    output logic [WORD-1:0]         reg_data_MEM_o,
    output logic                    is_valid_o,
    output reg_file_write_sig       reg_file_write_en_o,
    output logic [ADDR_WIDTH-1:0]   reg_dest_addr_o,
    output logic [WORD-1:0]         reg_write_data_o
);

    mem_stage_state state_q, state_d;
    access_decode_t dec;
    logic           is_store;
    logic           is_load;
    logic           mem_access;
    logic           align_misaligned;
    logic [WORD-1:0] load_data;

    assign dec        = decode_access(opA_opB_i);
    assign is_store   = (mem_write_en_i == MEM_WRITE_EN);
    assign is_load    = (reg_file_data_source_i == SRC_MEM);
    assign mem_access = is_valid_i & (is_store | is_load);

    load_store_align u_align (
        .size       (dec.size),
        .is_signed  (dec.is_signed),
        .addr_lo    (alu_result_i[1:0]),
        .store_data (reg_2_data_i),
        .rdata      (dmem_rdata_i),
        .be         (dmem_be_o),
        .wdata      (dmem_wdata_o),
        .load_data  (load_data),
        .misaligned (align_misaligned)
    );

    assign dmem_addr_o = {alu_result_i[WORD-1:2], 2'b00};
    assign dmem_we_o   = dmem_req_o & is_store;

    // Forwarding comes straight from EX/MEM; load data is never forwarded from here.
    assign reg_write_en_MEM_o = (is_valid_i && !is_load) ? reg_file_write_en_i : REG_WRITE_DIS;
    assign reg_dest_MEM_o     = reg_dest_addr_i;
    assign reg_data_MEM_o     = alu_result_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_o   = 1'b0;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        if (!reset_i) begin
            case (state_q)
                IDLE: begin
                    if (mem_access) begin
                        dmem_req_o   = 1'b1;
                        misaligned_o = align_misaligned;
                        if (!dmem_ack_i) begin
                            stall_o = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    dmem_req_o = 1'b1;
                    if (dmem_ack_i) begin
                        state_d = IDLE;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A stalled cycle inserts a bubble; stores complete valid but never write back.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= REG_WRITE_DIS;
            reg_dest_addr_o     <= '0;
            reg_write_data_o    <= '0;
        end else if (stall_o) begin
            is_valid_o          <= 1'b0;
            reg_file_write_en_o <= REG_WRITE_DIS;
        end else begin
            is_valid_o          <= is_valid_i;
            reg_file_write_en_o <= (is_valid_i && !is_store) ? reg_file_write_en_i : REG_WRITE_DIS;
            reg_dest_addr_o     <= reg_dest_addr_i;
            reg_write_data_o    <= is_load ? load_data : alu_result_i;
        end
    end

endmodule

// File: tb/tb_memory_access_block.sv
// tb/tb_memory_access_block.sv - directed self-checking bench for memory_access_block
module tb_memory_access_block;
    import memory_access_block_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic                  is_valid_i;
    mem_write_signal       mem_write_en_i;
    reg_file_write_sig     reg_file_write_en_i;
    reg_file_data_source   reg_file_data_source_i;
    logic [6:0]            opA_opB_i;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_i;
    logic [WORD-1:0]       alu_result_i;
    logic [WORD-1:0]       reg_2_data_i;
    logic [WORD-1:0]       dmem_rdata_i;
    logic                  dmem_ack_i;
    logic                  dmem_req_o;
    logic                  dmem_we_o;
    logic [WORD-1:0]       dmem_addr_o;
    logic [3:0]            dmem_be_o;
    logic [WORD-1:0]       dmem_wdata_o;
    logic                  stall_o;
    logic                  misaligned_o;
    reg_file_write_sig     reg_write_en_MEM_o;
    logic [ADDR_WIDTH-1:0] reg_dest_MEM_o;
    logic [WORD-1:0]       reg_data_MEM_o;
    logic                  is_valid_o;
    reg_file_write_sig     reg_file_write_en_o;
    logic [ADDR_WIDTH-1:0] reg_dest_addr_o;
    logic [WORD-1:0]       reg_write_data_o;

    int checks = 0;
    int errors = 0;

    memory_access_block dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .is_valid_i             (is_valid_i),
        .mem_write_en_i         (mem_write_en_i),
        .reg_file_write_en_i    (reg_file_write_en_i),
        .reg_file_data_source_i (reg_file_data_source_i),
        .opA_opB_i              (opA_opB_i),
        .reg_dest_addr_i        (reg_dest_addr_i),
        .alu_result_i           (alu_result_i),
        .reg_2_data_i           (reg_2_data_i),
        .dmem_rdata_i           (dmem_rdata_i),
        .dmem_ack_i             (dmem_ack_i),
        .dmem_req_o             (dmem_req_o),
        .dmem_we_o              (dmem_we_o),
        .dmem_addr_o            (dmem_addr_o),
        .dmem_be_o              (dmem_be_o),
        .dmem_wdata_o           (dmem_wdata_o),
        .stall_o                (stall_o),
        .misaligned_o           (misaligned_o),
        .reg_write_en_MEM_o     (reg_write_en_MEM_o),
        .reg_dest_MEM_o         (reg_dest_MEM_o),
        .reg_data_MEM_o         (reg_data_MEM_o),
        .is_valid_o             (is_valid_o),
        .reg_file_write_en_o    (reg_file_write_en_o),
        .reg_dest_addr_o        (reg_dest_addr_o),
        .reg_write_data_o       (reg_write_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [6:0]  opab;
        logic        we;
        logic        src;
        logic        rfwe;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rd;
        logic [3:0]  dest;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
        logic        e_fwd_we;
        logic        e_valid;
        logic        e_rfwe;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        is_valid_i             = 1'b0;
        mem_write_en_i         = MEM_WRITE_DIS;
        reg_file_write_en_i    = REG_WRITE_DIS;
        reg_file_data_source_i = SRC_ALU;
        opA_opB_i              = 7'd0;
        reg_dest_addr_i        = 4'd0;
        alu_result_i           = 32'd0;
        reg_2_data_i           = 32'd0;
        dmem_rdata_i           = 32'd0;
        dmem_ack_i             = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        is_valid_i             = v.valid;
        opA_opB_i              = v.opab;
        mem_write_en_i         = v.we ? MEM_WRITE_EN : MEM_WRITE_DIS;
        reg_file_data_source_i = v.src ? SRC_MEM : SRC_ALU;
        reg_file_write_en_i    = v.rfwe ? REG_WRITE_EN : REG_WRITE_DIS;
        alu_result_i           = v.alu;
        reg_2_data_i           = v.sd;
        dmem_rdata_i           = v.rd;
        reg_dest_addr_i        = v.dest;
    endtask

    int stall_cycles;

    initial begin
        //         valid opab        we src rfwe alu           sd            rd            dest  req be       wdata         mis fwd val rfwe data
        vecs[0]  = '{1'b1, 7'b0101000, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        4'd5, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 7'b0101010, 1'b1, 1'b0, 1'b0, 32'h101, 32'h000000AB, 32'h0,        4'd5, 1'b1, 4'b0010, 32'hABABABAB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 7'b0101001, 1'b1, 1'b0, 1'b0, 32'h102, 32'h00001234, 32'h0,        4'd5, 1'b1, 4'b1100, 32'h12341234, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 7'b0101101, 1'b0, 1'b1, 1'b1, 32'h202, 32'h0,        32'h80010000, 4'd6, 1'b1, 4'b1100, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h00008001};
        vecs[4]  = '{1'b1, 7'b0101111, 1'b0, 1'b1, 1'b1, 32'h202, 32'h0,        32'h80010000, 4'd6, 1'b1, 4'b1100, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF8001};
        vecs[5]  = '{1'b1, 7'b0101100, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0,        32'h11223344, 4'd1, 1'b1, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h11223344};
        vecs[6]  = '{1'b1, 7'b0111100, 1'b0, 1'b1, 1'b1, 32'h201, 32'h0,        32'h00009A00, 4'd2, 1'b1, 4'b0010, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0000009A};
        vecs[7]  = '{1'b1, 7'b1001100, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0,        32'hCAFEF00D, 4'd4, 1'b1, 4'b1111, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D};
        vecs[8]  = '{1'b1, 7'b0001100, 1'b0, 1'b0, 1'b1, 32'h55,  32'h0,        32'h0,        4'd3, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h00000055};
        vecs[9]  = '{1'b1, 7'b1000100, 1'b0, 1'b1, 1'b1, 32'h203, 32'h0,        32'hABCD0000, 4'd7, 1'b1, 4'b1100, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0000ABCD};
        vecs[10] = '{1'b0, 7'b0101000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h12345678, 32'h0,        4'd5, 1'b0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 7'b0110000, 1'b1, 1'b0, 1'b0, 32'h104, 32'h01020304, 32'h0,        4'd5, 1'b1, 4'b1111, 32'h01020304, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};

        idle_inputs();
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_req", dmem_req_o, 1'b0);
        check("reset_stall", stall_o, 1'b0);
        check("reset_mis", misaligned_o, 1'b0);
        check("reset_valid", is_valid_o, 1'b0);
        check("reset_rfwe", reg_file_write_en_o, REG_WRITE_DIS);
        check("reset_data", reg_write_data_o, 32'h0);
        check("reset_dest", reg_dest_addr_o, 4'h0);
        reset_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            drive(vecs[i]);
            dmem_ack_i = 1'b1;
            #1;
            check($sformatf("v%0d_req", i), dmem_req_o, vecs[i].e_req);
            check($sformatf("v%0d_stall", i), stall_o, 1'b0);
            check($sformatf("v%0d_mis", i), misaligned_o, vecs[i].e_mis);
            check($sformatf("v%0d_fwd_we", i), reg_write_en_MEM_o, vecs[i].e_fwd_we);
            check($sformatf("v%0d_fwd_dest", i), reg_dest_MEM_o, vecs[i].dest);
            check($sformatf("v%0d_fwd_data", i), reg_data_MEM_o, vecs[i].alu);
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_we", i), dmem_we_o, vecs[i].we);
                check($sformatf("v%0d_be", i), dmem_be_o, vecs[i].e_be);
                check($sformatf("v%0d_addr", i), dmem_addr_o, vecs[i].alu & 32'hFFFFFFFC);
                if (vecs[i].we)
                    check($sformatf("v%0d_wdata", i), dmem_wdata_o, vecs[i].e_wdata);
            end
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_wb_valid", i), is_valid_o, vecs[i].e_valid);
            check($sformatf("v%0d_wb_rfwe", i), reg_file_write_en_o, vecs[i].e_rfwe);
            if (vecs[i].e_valid && vecs[i].e_rfwe) begin
                check($sformatf("v%0d_wb_data", i), reg_write_data_o, vecs[i].e_data);
                check($sformatf("v%0d_wb_dest", i), reg_dest_addr_o, vecs[i].dest);
            end
        end

        // LDRSB at 0x203 with three wait cycles
        @(negedge clk_i);
        idle_inputs();
        is_valid_i             = 1'b1;
        opA_opB_i              = 7'b0101011;
        reg_file_data_source_i = SRC_MEM;
        reg_file_write_en_i    = REG_WRITE_EN;
        alu_result_i           = 32'h203;
        dmem_rdata_i           = 32'h80FF7F01;
        reg_dest_addr_i        = 4'd7;
        stall_cycles           = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk_i);
            dmem_ack_i = (c == 3);
            #1;
            if (stall_o) stall_cycles++;
            check("ldrsb_req_held", dmem_req_o, 1'b1);
            check("ldrsb_addr_held", dmem_addr_o, 32'h200);
            check("ldrsb_be_held", dmem_be_o, 4'b1000);
            @(posedge clk_i);
            #1;
            if (c < 3) check("ldrsb_bubble", is_valid_o, 1'b0);
        end
        check("ldrsb_stall_cycles", stall_cycles, 3);
        check("ldrsb_wb_valid", is_valid_o, 1'b1);
        check("ldrsb_wb_rfwe", reg_file_write_en_o, REG_WRITE_EN);
        check("ldrsb_wb_data", reg_write_data_o, 32'hFFFFFF80);
        check("ldrsb_wb_dest", reg_dest_addr_o, 4'd7);

        // Misaligned LDR with one wait cycle: pulse only in the request cycle
        @(negedge clk_i);
        idle_inputs();
        is_valid_i             = 1'b1;
        opA_opB_i              = 7'b0101100;
        reg_file_data_source_i = SRC_MEM;
        reg_file_write_en_i    = REG_WRITE_EN;
        alu_result_i           = 32'h102;
        dmem_rdata_i           = 32'h0BADC0DE;
        reg_dest_addr_i        = 4'd2;
        #1;
        check("mis_pulse_first", misaligned_o, 1'b1);
        check("mis_addr", dmem_addr_o, 32'h100);
        check("mis_stall", stall_o, 1'b1);
        @(negedge clk_i);
        dmem_ack_i = 1'b1;
        #1;
        check("mis_pulse_second", misaligned_o, 1'b0);
        check("mis_req_wait", dmem_req_o, 1'b1);
        check("mis_stall_ack", stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("mis_wb_data", reg_write_data_o, 32'h0BADC0DE);

        // Reset while waiting, then a late ack that must be ignored
        @(negedge clk_i);
        idle_inputs();
        is_valid_i             = 1'b1;
        opA_opB_i              = 7'b0101100;
        reg_file_data_source_i = SRC_MEM;
        reg_file_write_en_i    = REG_WRITE_EN;
        alu_result_i           = 32'h400;
        dmem_rdata_i           = 32'h12345678;
        reg_dest_addr_i        = 4'd9;
        #1;
        check("rst_wait_stall", stall_o, 1'b1);
        @(negedge clk_i);
        reset_i    = 1'b1;
        is_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        #1;
        check("rst_after_stall", stall_o, 1'b0);
        check("rst_after_req", dmem_req_o, 1'b0);
        check("rst_after_valid", is_valid_o, 1'b0);
        @(negedge clk_i);
        dmem_ack_i = 1'b1;
        #1;
        check("late_ack_req", dmem_req_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("late_ack_valid", is_valid_o, 1'b0);
        check("late_ack_rfwe", reg_file_write_en_o, REG_WRITE_DIS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
